// File: rtl/integer_clk_div_if.sv
// Control and output bundle of integer_clk_div: enable and ratio in, divided clock and tick out.
// The reference clock and reset stay plain ports on the divider.
interface integer_clk_div_if #(
    parameter int unsigned RATIO_WD = 8
);
    logic                i_clk_en;
    logic [RATIO_WD-1:0] i_div_ratio;
    logic                o_div_clk;
    logic                o_div_tick;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_div_tick
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_div_tick
    );
endinterface

// File: rtl/integer_clk_div.sv
// Integer clock divider: low phase ceil(N/2), high phase floor(N/2), runt-free ratio updates.
// Define CLK_DIV_ODD_EN for exact odd ratios; otherwise the ratio LSB is ignored.
module integer_clk_div #(
    parameter int unsigned RATIO_WD = 8
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    integer_clk_div_if.slave bus
);

    localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);
    localparam logic [RATIO_WD-1:0] TWO = RATIO_WD'(2);

    function automatic logic [RATIO_WD-1:0] eff_ratio(input logic [RATIO_WD-1:0] n);
`ifdef CLK_DIV_ODD_EN
        return n;
`else
        return n & ~ONE;
`endif
    endfunction

    logic [RATIO_WD-1:0] r_ratio;
    logic [RATIO_WD-1:0] cnt;
    logic                div_q;
    logic                tick_q;

    logic [RATIO_WD-1:0] n_eff;
    logic [RATIO_WD-1:0] half_len;
    logic [RATIO_WD-1:0] low_len;
    logic [RATIO_WD-1:0] phase_len;
    logic                phase_end;
    logic                bypass;
    logic                new_ok;

    always_comb begin
        n_eff     = eff_ratio(r_ratio);
        half_len  = n_eff >> 1;
        low_len   = n_eff - half_len;
        phase_len = div_q ? half_len : low_len;
        phase_end = (cnt == phase_len - ONE);
        bypass    = !bus.i_clk_en || (r_ratio < TWO);
        new_ok    = (bus.i_div_ratio >= TWO);
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ratio <= '0;
            cnt     <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else if (bypass) begin
            r_ratio <= bus.i_div_ratio;
            cnt     <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else if (phase_end) begin
            cnt <= '0;
            if (div_q) begin
                div_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                // Ratio is only taken at the rising boundary; a ratio <2 drops straight to bypass.
                r_ratio <= bus.i_div_ratio;
                div_q   <= new_ok;
                tick_q  <= new_ok;
            end
        end else begin
            cnt    <= cnt + ONE;
            tick_q <= 1'b0;
        end
    end

    assign bus.o_div_clk  = bypass ? i_ref_clk : div_q;
    assign bus.o_div_tick = tick_q && !bypass;

endmodule

// File: tb/tb_integer_clk_div.sv
// Randomized self-checking bench for integer_clk_div against a queue-based waveform model.
// Honours CLK_DIV_ODD_EN the same way the design does.
module tb_integer_clk_div;

    localparam int unsigned W = 8;

    logic ref_clk = 1'b0;
    logic rst_n   = 1'b0;

    integer_clk_div_if #(.RATIO_WD(W)) bus ();

    integer_clk_div #(.RATIO_WD(W)) dut (
        .i_ref_clk (ref_clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    always #5 ref_clk = ~ref_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Upcoming ref cycles of the divided clock; front entry is the current cycle.
    typedef struct packed {
        logic lvl;
        logic tick;
        logic rs;
    } ent_t;

    ent_t sched[$];
    int   m_ratio    = 0;
    int   cyc        = 0;
    int   last_tick  = -1;
    int   last_gap   = 0;
    int   first_tick = -1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int eff(input int n);
`ifdef CLK_DIV_ODD_EN
        return n;
`else
        return n & ~1;
`endif
    endfunction

    function automatic int hi_len(input int n);
        return eff(n) / 2;
    endfunction

    function automatic int lo_len(input int n);
        return eff(n) - eff(n) / 2;
    endfunction

    function automatic void push_low(input int n);
        for (int i = 0; i < lo_len(n); i++) begin
            ent_t e;
            e.lvl  = 1'b0;
            e.tick = 1'b0;
            e.rs   = (i == lo_len(n) - 1);
            sched.push_back(e);
        end
    endfunction

    function automatic void push_high(input int n);
        for (int i = 0; i < hi_len(n); i++) begin
            ent_t e;
            e.lvl  = 1'b1;
            e.tick = (i == 0);
            e.rs   = 1'b0;
            sched.push_back(e);
        end
    endfunction

    function automatic logic model_bypass();
        return !bus.i_clk_en || (m_ratio < 2);
    endfunction

    // Advance the model across one rising ref edge using the inputs present at that edge.
    function automatic void model_edge();
        ent_t e;
        if (!rst_n) begin
            m_ratio = 0;
            sched.delete();
        end else if (model_bypass()) begin
            m_ratio = int'(bus.i_div_ratio);
            sched.delete();
            if (m_ratio >= 2) push_low(m_ratio);
        end else if (sched.size() > 0) begin
            e = sched.pop_front();
            if (e.rs) begin
                m_ratio = int'(bus.i_div_ratio);
                sched.delete();
                if (m_ratio >= 2) begin
                    push_high(m_ratio);
                    push_low(m_ratio);
                end
            end
        end
    endfunction

    // One ref cycle: output sampled in both clock halves, plus the tick.
    task automatic cycle(input string tag);
        logic       hi;
        logic       lo;
        logic       tk;
        logic [2:0] exp;
        @(posedge ref_clk);
        model_edge();
        cyc++;
        #1;
        hi = bus.o_div_clk;
        tk = bus.o_div_tick;
        @(negedge ref_clk);
        #1;
        lo = bus.o_div_clk;
        if (model_bypass())        exp = 3'b100;
        else if (sched.size() > 0) exp = {sched[0].lvl, sched[0].lvl, sched[0].tick};
        else                       exp = 3'b111;
        check(tag, int'({hi, lo, tk}), int'(exp));
        if (tk) begin
            if (last_tick >= 0) last_gap = cyc - last_tick;
            last_tick = cyc;
            if (first_tick < 0) first_tick = cyc;
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic wait_level(input string tag, input logic want);
        int k = 0;
        while (!(sched.size() > 0 && sched[0].lvl == want && !model_bypass()) && k < 300) begin
            cycle(tag);
            k++;
        end
        check({tag, "_reach"}, int'(k < 300), 1);
    endtask

    task automatic drive(input logic en, input int ratio);
        bus.i_clk_en    = en;
        bus.i_div_ratio = W'(ratio);
        last_tick       = -1;
    endtask

    int base;
    int r;

    initial begin
        bus.i_clk_en    = 1'b0;
        bus.i_div_ratio = '0;
        rst_n           = 1'b0;

        // Reset: bypass, no tick
        run("reset", 3);
        check("reset_tick", int'(bus.o_div_tick), 0);
        rst_n = 1'b1;
        run("idle", 3);

        // Scenario 1: N=4, first rise on 2nd active edge, period 4
        drive(1'b1, 4);
        first_tick = -1;
        base = cyc;
        run("s1", 22);
        check("s1_first", first_tick - base, 3);
        check("s1_gap", last_gap, 4);

        // Scenario 2: N=5
        drive(1'b0, 5);
        run("s2_off", 2);
        drive(1'b1, 5);
        run("s2", 30);
        check("s2_gap", last_gap, eff(5));

        // Scenario 3: bypass cases
        drive(1'b1, 0);
        run("s3_n0", 6);
        drive(1'b1, 1);
        run("s3_n1", 6);
        drive(1'b0, 4);
        run("s3_off", 6);

        // Scenario 4: 4 -> 8 changed in the low phase
        drive(1'b1, 4);
        run("s4_pre", 6);
        wait_level("s4_low", 1'b0);
        drive(1'b1, 8);
        run("s4", 30);
        check("s4_gap", last_gap, 8);

        // Scenario 5: async reset in the high phase at N=2
        drive(1'b1, 2);
        run("s5_pre", 5);
        wait_level("s5_high", 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("s5_async_clk", int'(bus.o_div_clk), 0);
        check("s5_async_tick", int'(bus.o_div_tick), 0);
        run("s5_rst", 3);
        rst_n = 1'b1;
        run("s5", 10);
        check("s5_gap", last_gap, 2);

        // Scenario 6: maximum ratio
        drive(1'b1, 255);
        run("s6", 600);
        check("s6_gap", last_gap, eff(255));

        // Random ratios, enables and resets
        for (int seg = 0; seg < 150; seg++) begin
            case ($urandom_range(0, 7))
                0:       r = 0;
                1:       r = 1;
                2:       r = 2;
                3:       r = 3;
                4:       r = 4;
                5:       r = 5;
                6:       r = 8;
                default: r = int'($urandom_range(2, 20));
            endcase
            drive($urandom_range(0, 9) != 0, r);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                run("rnd_rst", 2);
                rst_n = 1'b1;
            end
            run("rnd", int'($urandom_range(1, 25)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
